// File: rtl/xip_flash_wakeup_if.sv
// Pin bundle between the Murax XIP port, the SPI flash pins and the core reset/ready lines.
interface xip_flash_wakeup_if;
   logic [1:0] io_xip_sclk_write;
   logic [1:0] io_xip_data_0_write;
   logic       io_xip_data_0_writeEnable;
   logic       io_xip_ss;
   logic [1:0] io_xip_data_1_read;
   logic       io_flash_sclk;
   logic       io_flash_mosi;
   logic       io_flash_miso;
   logic       io_flash_ss;
   logic       io_coreReset;
   logic       io_ready;

   modport slave (
      input  io_xip_sclk_write, io_xip_data_0_write, io_xip_data_0_writeEnable,
             io_xip_ss, io_flash_miso,
      output io_xip_data_1_read, io_flash_sclk, io_flash_mosi, io_flash_ss,
             io_coreReset, io_ready
   );

   modport master (
      output io_xip_sclk_write, io_xip_data_0_write, io_xip_data_0_writeEnable,
             io_xip_ss, io_flash_miso,
      input  io_xip_data_1_read, io_flash_sclk, io_flash_mosi, io_flash_ss,
             io_coreReset, io_ready
   );
endinterface

// File: rtl/xip_flash_wakeup.sv
// Power-up sequencer: wakes the SPI flash from deep power-down, then passes the
// flash pins through to the Murax XIP controller and releases the core reset.
module xip_flash_wakeup #(
   parameter int          CLK_DIV     = 4,
   parameter logic [7:0]  WAKE_CMD    = 8'hAB,
   parameter int          HOLD_CYCLES = 16,
   parameter int          WAIT_CYCLES = 600
) (
   input  logic               io_mainClk,
   input  logic               io_asyncResetn,
   xip_flash_wakeup_if.slave  bus
);

   localparam int SPAN = 2 * CLK_DIV;
   localparam int MAXC = (HOLD_CYCLES > SPAN)
                         ? ((HOLD_CYCLES > WAIT_CYCLES) ? HOLD_CYCLES : WAIT_CYCLES)
                         : ((SPAN > WAIT_CYCLES) ? SPAN : WAIT_CYCLES);
   localparam int CW   = $clog2(MAXC) + 1;

   localparam logic [CW-1:0] HOLD_END   = CW'(HOLD_CYCLES);
   localparam logic [CW-1:0] BIT_END    = CW'(SPAN - 1);
   localparam logic [CW-1:0] HIGH_START = CW'(CLK_DIV);
   localparam logic [CW-1:0] WAIT_END   = CW'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_HOLD, S_SHIFT, S_WAIT, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic            ss_q, ss_d;
   logic            sclk_q, sclk_d;
   logic            mosi_q, mosi_d;
   logic            sel_q, sel_d;

   // State, counters and registered pin drivers; reset forces idle pins at once.
   always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
      if (!io_asyncResetn) begin
         state_q <= S_HOLD;
         cnt_q   <= '0;
         bit_q   <= '0;
         ss_q    <= 1'b1;
         sclk_q  <= 1'b0;
         mosi_q  <= 1'b0;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         ss_q    <= ss_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         sel_q   <= sel_d;
      end
   end

   // Sequencing: HOLD settle, 8 SPI mode-0 bits, post-command wait, then DONE forever.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      unique case (state_q)
         S_HOLD: begin
            if (cnt_q == HOLD_END) begin
               state_d = S_SHIFT;
               cnt_d   = '0;
               bit_d   = 3'd7;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (cnt_q == BIT_END) begin
               cnt_d = '0;
               if (bit_q == 3'd0) state_d = S_WAIT;
               else               bit_d   = bit_q - 3'd1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_WAIT: begin
            if (cnt_q == WAIT_END) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Pin values are derived from the next state so each pin is a plain flop output.
   always_comb begin
      ss_d   = 1'b1;
      sclk_d = 1'b0;
      mosi_d = 1'b0;
      sel_d  = 1'b0;
      unique case (state_d)
         S_SHIFT: begin
            ss_d   = 1'b0;
            sclk_d = (cnt_d >= HIGH_START);
            mosi_d = WAKE_CMD[bit_d];
         end
         S_DONE:  sel_d = 1'b1;
         default: ;
      endcase
   end

   assign bus.io_flash_sclk      = sel_q ? bus.io_xip_sclk_write[0]   : sclk_q;
   assign bus.io_flash_mosi      = sel_q ? bus.io_xip_data_0_write[0] : mosi_q;
   assign bus.io_flash_ss        = sel_q ? bus.io_xip_ss              : ss_q;
   assign bus.io_xip_data_1_read = {2{bus.io_flash_miso}};
   assign bus.io_coreReset       = ~sel_q;
   assign bus.io_ready           = sel_q;

   logic unused_xip_bits;
   assign unused_xip_bits = ^{bus.io_xip_sclk_write[1], bus.io_xip_data_0_write[1],
                              bus.io_xip_data_0_writeEnable};

endmodule

// File: tb/tb_xip_flash_wakeup.sv
// Bench for xip_flash_wakeup: default instance plus a minimum-timing instance,
// both checked every cycle against a cycle-indexed waveform model.
module tb_xip_flash_wakeup;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;

   xip_flash_wakeup_if a_if ();
   xip_flash_wakeup_if b_if ();

   xip_flash_wakeup dut_a (
      .io_mainClk     (clk),
      .io_asyncResetn (rst_a),
      .bus            (a_if.slave)
   );

   xip_flash_wakeup #(
      .CLK_DIV     (1),
      .WAKE_CMD    (8'hAB),
      .HOLD_CYCLES (1),
      .WAIT_CYCLES (1)
   ) dut_b (
      .io_mainClk     (clk),
      .io_asyncResetn (rst_b),
      .bus            (b_if.slave)
   );

   int   checks = 0;
   int   errors = 0;
   int   e_a = -1;
   int   e_b = -1;
   int   rise_a[$];
   logic mbit_a[$];
   int   rise_b_n = 0;
   logic prev_a = 1'b0;
   logic prev_b = 1'b0;

   // Expected {ss, sclk, mosi, ready, coreReset, miso_read[1:0]} after edge e (-1: no edge yet)
   function automatic logic [6:0] model(input int e, input int h, input int d, input int w,
                                        input logic [1:0] sck, input logic [1:0] mo,
                                        input logic ss, input logic mi);
      logic [7:0] cmd;
      logic [6:0] r;
      int s;
      cmd = 8'hAB;
      r = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, mi, mi};
      if (e >= h + 16 * d + w) begin
         r = {ss, sck[0], mo[0], 1'b1, 1'b0, mi, mi};
      end else if (e >= h && e < h + 16 * d) begin
         s    = e - h;
         r[6] = 1'b0;
         r[5] = ((s % (2 * d)) >= d);
         r[4] = cmd[7 - s / (2 * d)];
      end
      return r;
   endfunction

   task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sample(input string tag);
      compare({tag, "_a"},
              32'({a_if.io_flash_ss, a_if.io_flash_sclk, a_if.io_flash_mosi,
                   a_if.io_ready, a_if.io_coreReset, a_if.io_xip_data_1_read}),
              32'(model(e_a, 16, 4, 600, a_if.io_xip_sclk_write, a_if.io_xip_data_0_write,
                        a_if.io_xip_ss, a_if.io_flash_miso)));
      compare({tag, "_b"},
              32'({b_if.io_flash_ss, b_if.io_flash_sclk, b_if.io_flash_mosi,
                   b_if.io_ready, b_if.io_coreReset, b_if.io_xip_data_1_read}),
              32'(model(e_b, 1, 1, 1, b_if.io_xip_sclk_write, b_if.io_xip_data_0_write,
                        b_if.io_xip_ss, b_if.io_flash_miso)));
   endtask

   task automatic drive_random();
      a_if.io_xip_sclk_write         = 2'($urandom);
      a_if.io_xip_data_0_write       = 2'($urandom);
      a_if.io_xip_data_0_writeEnable = 1'($urandom);
      a_if.io_xip_ss                 = 1'($urandom);
      a_if.io_flash_miso             = 1'($urandom);
      b_if.io_xip_sclk_write         = 2'($urandom);
      b_if.io_xip_data_0_write       = 2'($urandom);
      b_if.io_xip_data_0_writeEnable = 1'($urandom);
      b_if.io_xip_ss                 = 1'($urandom);
      b_if.io_flash_miso             = 1'($urandom);
   endtask

   task automatic run(input int n);
      repeat (n) begin
         @(posedge clk);
         if (rst_a) e_a++;
         if (rst_b) e_b++;
         #1;
         sample("edge");
         if (!a_if.io_ready && !prev_a && a_if.io_flash_sclk) begin
            rise_a.push_back(e_a);
            mbit_a.push_back(a_if.io_flash_mosi);
         end
         if (!b_if.io_ready && !prev_b && b_if.io_flash_sclk) rise_b_n++;
         prev_a = a_if.io_flash_sclk;
         prev_b = b_if.io_flash_sclk;
         drive_random();
         #1;
         sample("comb");
      end
   endtask

   task automatic check_rises_a(input string tag);
      logic [7:0] byte_seen;
      compare({tag, "_rise_count"}, 32'(rise_a.size()), 32'd8);
      if (rise_a.size() == 8) begin
         compare({tag, "_first_rise"}, 32'(rise_a[0]), 32'd20);
         for (int i = 1; i < 8; i++)
            compare({tag, "_rise_spacing"}, 32'(rise_a[i] - rise_a[i-1]), 32'd8);
         for (int i = 0; i < 8; i++) byte_seen[7 - i] = mbit_a[i];
         compare({tag, "_mosi_byte"}, 32'(byte_seen), 32'hAB);
      end
      rise_a.delete();
      mbit_a.delete();
   endtask

   task automatic reset_a_async(input string tag);
      #1;
      rst_a = 1'b0;
      e_a   = -1;
      #1;
      sample(tag);
      prev_a = 1'b0;
      rise_a.delete();
      mbit_a.delete();
      @(negedge clk);
      rst_a = 1'b1;
   endtask

   initial begin
      rst_a = 1'b0;
      rst_b = 1'b0;
      drive_random();
      repeat (3) @(posedge clk);
      #1;
      sample("reset");
      @(negedge clk);
      rst_a = 1'b1;
      rst_b = 1'b1;

      // Full default sequence plus minimum-timing instance, random XIP inputs throughout
      run(700);
      check_rises_a("boot");
      compare("b_rise_count", 32'(rise_b_n), 32'd8);

      // Reset in the high phase of bit 3 (edge 53), then full restart
      reset_a_async("pre_mid");
      run(54);
      compare("mid_sclk_high", 32'(a_if.io_flash_sclk), 32'd1);
      reset_a_async("mid_shift_reset");
      run(700);
      check_rises_a("restart");

      // Reset while in DONE, then rerun
      reset_a_async("done_reset");
      run(700);
      check_rises_a("rerun");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/xip_flash_wakeup.md
# xip_flash_wakeup

Power-up sequencer between Murax's XIP SPI port and the board's SPI flash pins on the iCE40-hx8k breakout. After reset it holds the SoC in reset and sends a Release-from-Deep-Power-Down command (0xAB) to the flash. It then waits the flash wake-up time and hands the pins to Murax's XIP controller as a pass-through. This is needed because iCE40 configuration can leave the flash in deep power-down, where XIP fetches return garbage.

## Interface
- CLK_DIV, 4: SCLK half-period in io_mainClk cycles, ≥1
- WAKE_CMD, 8'hAB: command byte shifted out MSB first
- HOLD_CYCLES, 16: settle delay before command, ≥1
- WAIT_CYCLES, 600: post-command wait (tRES1), ≥1
- io_mainClk  in  1  sole clock
- io_asyncResetn  in  1  reset, asynchronous, active-low
- io_xip_sclk_write  in  2  Murax XIP SCLK (bit 0 used)
- io_xip_data_0_write  in  2  Murax MOSI (bit 0 used)
- io_xip_data_0_writeEnable  in  1  ignored (MOSI always driven)
- io_xip_ss  in  1  Murax chip select, active-low
- io_xip_data_1_read  out  2  MISO to Murax, both bits = io_flash_miso
- io_flash_sclk  out  1  flash pin
- io_flash_mosi  out  1  flash pin
- io_flash_miso  in  1  flash pin
- io_flash_ss  out  1  flash chip select, active-low
- io_coreReset  out  1  active-high reset into Murax io_asyncReset
- io_ready  out  1  sequence complete, pins passed through

## Operation
- States: HOLD → SHIFT → WAIT → DONE. DONE is terminal until reset.
- HOLD: ss=1, sclk=0, mosi=0. Runs for HOLD_CYCLES cycles, then enters SHIFT.
- SHIFT: ss=0. SPI mode 0, 8 bits of WAKE_CMD, MSB first.
  - Each bit: CLK_DIV cycles with sclk=0 and mosi=bit, then CLK_DIV cycles with sclk=1 and mosi held.
  - Bit index advances when sclk falls. After bit 0's high phase, enter WAIT.
- WAIT: ss=1, sclk=0, mosi=0. Runs for WAIT_CYCLES cycles, then enters DONE.
- DONE: registered select bit `sel`=1. Combinational pass-through:
  - flash_sclk = xip_sclk_write[0]
  - flash_mosi = xip_data_0_write[0]
  - flash_ss = xip_ss
- io_coreReset = !sel and io_ready = sel, both registered. Murax pin inputs are ignored before DONE.
- io_xip_data_1_read = {io_flash_miso, io_flash_miso} at all times, unregistered. MISO is never sampled internally.
- Counter width: $clog2 of max(HOLD_CYCLES, 2*CLK_DIV, WAIT_CYCLES) + 1. Bit counter is 3 bits and does not wrap past bit 0.
- All flash pins are driven from registers before DONE; no glitches on the ss/sclk transitions.

## Timing
- Reset (io_asyncResetn=0), effective immediately:
  - state=HOLD, all counters 0, sel=0
  - io_flash_ss=1, io_flash_sclk=0, io_flash_mosi=0
  - io_coreReset=1, io_ready=0
- Deassertion is used directly; the board top supplies a clean release.
- Cycle 0 = first rising edge with io_asyncResetn=1. With T = HOLD_CYCLES + 16*CLK_DIV + WAIT_CYCLES:

- **ss:** falls after edge HOLD_CYCLES.
- **sclk:** first rising edge after edge HOLD_CYCLES + CLK_DIV.
- **ss release:** ss rises after edge HOLD_CYCLES + 16*CLK_DIV.
- **ready:** io_ready rises and io_coreReset falls after edge T (defaults: 680).

- Reset mid-sequence, in any state including DONE: immediate return to reset values, then a full restart. ss must go high asynchronously even in the middle of a bit.
- Murax cannot issue XIP traffic before DONE, because it is held in reset by io_coreReset.

## Test plan
- Defaults, release reset: io_flash_ss falls at cycle 16 and rises at cycle 80. Exactly 8 sclk rising edges occur, 8 cycles apart. On the rising edges, mosi reads 1,0,1,0,1,0,1,1 (0xAB). io_ready=1 and io_coreReset=0 at cycle 680.
- CLK_DIV=1, WAIT_CYCLES=1, HOLD_CYCLES=1: sclk toggles every cycle. ready rises after edge 18. No extra sclk edges.
- Pass-through after DONE: drive xip_sclk/mosi/ss with random patterns. The flash pins match in the same cycle. io_flash_miso=1 → io_xip_data_1_read=2'b11.
- Before DONE, toggle all io_xip_* inputs: flash pins follow only the sequencer pattern.
- Pull io_asyncResetn low during bit 3 of SHIFT: ss=1, sclk=0, coreReset=1 with no clock edge. On release, the full sequence restarts and completes at cycle 680.
- Reset asserted in DONE: pins return to idle, ready=0, and the sequence reruns correctly.
